fp_r4_wb_sched: RTL

Issue scheduler for the fused multiply-add (R4) pipeline and the standalone FP add/sub pipeline, which share one FP register-file write port. It grants requests from the FP issue stage and reserves the writeback slot for each granted op. It tracks pending FP destinations in a scoreboard, so RAW and WAW hazards are stalled. It drives the registered writeback descriptor (valid, rd, source) that the write-port mux consumes.

---
 rtl/fp_r4_wb_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fp_r4_wb_sched.sv
// fp_r4_wb_sched: issue scheduler for the R4 (FMA) and FP add/sub pipes that share one RF write port.
// Optional macro FP_R4_SCHED_BYPASS_EN lets source checks ignore the register written back this cycle.
module fp_r4_wb_sched #(
  parameter int R4_LAT     = 8,
  parameter int FADD_LAT   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush_i,
  input  logic        r4_req_i,
  input  logic [4:0]  r4_rd_i,
  input  logic [4:0]  r4_rs1_i,
  input  logic [4:0]  r4_rs2_i,
  input  logic [4:0]  r4_rs3_i,
  input  logic        fadd_req_i,
  input  logic [4:0]  fadd_rd_i,
  input  logic [4:0]  fadd_rs1_i,
  input  logic [4:0]  fadd_rs2_i,
  output logic        r4_gnt_o,
  output logic        fadd_gnt_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_src_o,
  output logic        busy_o,
  output logic [31:0] pending_o
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // slot[k] holds the op whose result reaches the write port k cycles after the current edge
  logic [R4_LAT:1]  slot_vld, slot_vld_nx;
  logic [R4_LAT:1]  slot_src, slot_src_nx;
  logic [4:0]       slot_rd    [1:R4_LAT];
  logic [4:0]       slot_rd_nx [1:R4_LAT];
  logic [31:0]      pend, pend_nx, src_pend;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nx;

  logic wb_fire, issue_ok, lock, slot_conf;
  logic r4_haz, fadd_haz, fadd_gnt, r4_gnt, starve_inc;

  assign wb_fire = slot_vld[1] & en;

  always_comb begin
    src_pend = pend;
`ifdef FP_R4_SCHED_BYPASS_EN
    if (wb_fire) src_pend[slot_rd[1]] = 1'b0;
`endif
  end

  assign issue_ok  = rst & en & ~flush_i;
  assign lock      = (starve_cnt == CNT_MAX);
  assign slot_conf = slot_vld[FADD_LAT+1];

  assign r4_haz   = src_pend[r4_rs1_i] | src_pend[r4_rs2_i] | src_pend[r4_rs3_i] | pend[r4_rd_i];
  assign fadd_haz = src_pend[fadd_rs1_i] | src_pend[fadd_rs2_i] | pend[fadd_rd_i];

  assign fadd_gnt = issue_ok & fadd_req_i & ~fadd_haz & ~slot_conf;
  // a same-rd pair in one cycle is resolved in favour of fadd
  assign r4_gnt   = issue_ok & r4_req_i & ~r4_haz & ~lock &
                    ~(fadd_gnt & (fadd_rd_i == r4_rd_i));

  assign starve_inc = issue_ok & fadd_req_i & ~fadd_haz & slot_conf & (starve_cnt < CNT_MAX);

  always_comb begin
    slot_vld_nx   = slot_vld;
    slot_src_nx   = slot_src;
    for (int k = 1; k <= R4_LAT; k++) slot_rd_nx[k] = slot_rd[k];
    pend_nx       = pend;
    starve_cnt_nx = starve_cnt;
    if (en) begin
      for (int k = 1; k < R4_LAT; k++) begin
        slot_vld_nx[k] = slot_vld[k+1];
        slot_src_nx[k] = slot_src[k+1];
        slot_rd_nx[k]  = slot_rd[k+1];
      end
      slot_vld_nx[R4_LAT] = 1'b0;
      slot_src_nx[R4_LAT] = 1'b0;
      slot_rd_nx[R4_LAT]  = '0;
      if (wb_fire) pend_nx[slot_rd[1]] = 1'b0;
      if (r4_gnt) begin
        slot_vld_nx[R4_LAT] = 1'b1;
        slot_src_nx[R4_LAT] = 1'b1;
        slot_rd_nx[R4_LAT]  = r4_rd_i;
        pend_nx[r4_rd_i]    = 1'b1;
      end
      if (fadd_gnt) begin
        slot_vld_nx[FADD_LAT] = 1'b1;
        slot_src_nx[FADD_LAT] = 1'b0;
        slot_rd_nx[FADD_LAT]  = fadd_rd_i;
        pend_nx[fadd_rd_i]    = 1'b1;
      end
      if (fadd_gnt || !fadd_req_i) starve_cnt_nx = '0;
      else if (starve_inc)         starve_cnt_nx = starve_cnt + 1'b1;
    end
  end

  // flush and reset both discard every in-flight op on the same edge
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      slot_vld   <= '0;
      slot_src   <= '0;
      pend       <= '0;
      starve_cnt <= '0;
      for (int k = 1; k <= R4_LAT; k++) slot_rd[k] <= '0;
    end else begin
      slot_vld   <= slot_vld_nx;
      slot_src   <= slot_src_nx;
      pend       <= pend_nx;
      starve_cnt <= starve_cnt_nx;
      for (int k = 1; k <= R4_LAT; k++) slot_rd[k] <= slot_rd_nx[k];
    end
  end

  assign r4_gnt_o   = r4_gnt;
  assign fadd_gnt_o = fadd_gnt;
  assign wb_valid_o = rst & slot_vld[1];
  assign wb_rd_o    = rst ? slot_rd[1] : 5'd0;
  assign wb_src_o   = rst & slot_src[1];
  assign busy_o     = rst & ((|slot_vld) | (|pend));
  assign pending_o  = rst ? pend : 32'd0;

endmodule
